// File: rtl/io_timer_pkg.sv
// rtl/io_timer_pkg.sv - shared IO constants, register offsets and CTRL/STATUS bit positions
package io_timer_pkg;

  // IO page that all memory-mapped peripherals live in
  localparam logic [7:0] IO_PAGE = 8'h10;

  // Register offsets inside the 8-byte window
  typedef enum logic [2:0] {
    OFF_CTRL   = 3'd0,
    OFF_STATUS = 3'd1,
    OFF_CMP_L  = 3'd2,
    OFF_CMP_H  = 3'd3,
    OFF_CNT_L  = 3'd4,
    OFF_CNT_H  = 3'd5,
    OFF_DUTY_L = 3'd6,
    OFF_DUTY_H = 3'd7
  } regOffset_e;

  // CTRL bit positions; PS occupies CTRL_PS upwards
  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_AR   = 2;
  localparam int CTRL_PS   = 4;

  // STATUS bit positions
  localparam int STATUS_MF = 0;

  localparam logic [15:0] CMP_RESET = 16'hFFFF;

  // Register offset carried in the low address bits
  function automatic regOffset_e regOffset(input logic [15:0] addr);
    return regOffset_e'(addr[2:0]);
  endfunction

endpackage

// File: rtl/io_timer_if.sv
// rtl/io_timer_if.sv - CPU data-memory/IO bus plus interrupt line for the timer
interface io_timer_if;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        write_en;
  logic        read_en;
  logic        irq;
  logic        irq_clr;

  // CPU side
  modport master (
    output addr, din, write_en, read_en, irq_clr,
    input  dout, irq
  );

  // Peripheral side
  modport slave (
    input  addr, din, write_en, read_en, irq_clr,
    output dout, irq
  );
endinterface

// File: rtl/io_prescaler.sv
// rtl/io_prescaler.sv - free-running 8-bit divider producing a tick every 2^ps clocks
module io_prescaler #(
  parameter int PS_BITS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic [PS_BITS-1:0] ps,
  output logic               tick
);

  logic [7:0]  div;
  logic [15:0] fullMask;
  logic [7:0]  mask;

  // Low ps bits of the divider all ones marks the last clock of a period
  always_comb begin
    fullMask = (16'd1 << ps) - 16'd1;
    mask     = fullMask[7:0];
    tick     = ((div & mask) == mask);
  end

  // Divider runs freely and restarts from zero whenever clr is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= 8'd0;
    end else if (clr) begin
      div <= 8'd0;
    end else begin
      div <= div + 8'd1;
    end
  end

endmodule

// File: rtl/io_timer.sv
// rtl/io_timer.sv - memory-mapped 16-bit timer/compare peripheral; PWM output with IO_TIMER_PWM_EN
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR     = {IO_PAGE, 8'h00},
  parameter int          PRESCALE_BITS = 3
) (
  input  logic       clk,
  input  logic       reset,
  io_timer_if.slave  bus
`ifdef IO_TIMER_PWM_EN
  ,
  output logic       pwm_out
`endif
);

  // Register state
  logic                     en;
  logic                     ie;
  logic                     ar;
  logic [PRESCALE_BITS-1:0] ps;
  logic                     mf;
  logic [15:0]              cmp;
  logic [15:0]              cnt;
  logic [7:0]               tmpHi;
  logic [7:0]               cntHiShadow;
  logic [7:0]               doutReg;
  logic [15:0]              dutyRead;

  // Bus decode
  logic       sel;
  regOffset_e offset;
  logic       wrStrobe;
  logic       rdStrobe;
  logic       ctrlWr;
  logic       statusWr;
  logic       cmpLoWr;
  logic       cmpHiWr;
  logic       cntLoWr;
  logic       cntHiWr;
  logic       cntLoRd;
  logic [7:0] readMux;
  logic [7:0] ctrlRead;

  // Counter control
  logic tick;
  logic prescClr;
  logic countStep;
  logic matchEvent;

  assign sel      = (bus.addr[15:3] == BASE_ADDR[15:3]);
  assign offset   = regOffset(bus.addr);
  assign wrStrobe = bus.write_en && sel;
  assign rdStrobe = bus.read_en && sel;

  assign ctrlWr   = wrStrobe && (offset == OFF_CTRL);
  assign statusWr = wrStrobe && (offset == OFF_STATUS);
  assign cmpLoWr  = wrStrobe && (offset == OFF_CMP_L);
  assign cmpHiWr  = wrStrobe && (offset == OFF_CMP_H);
  assign cntLoWr  = wrStrobe && (offset == OFF_CNT_L);
  assign cntHiWr  = wrStrobe && (offset == OFF_CNT_H);
  assign cntLoRd  = rdStrobe && (offset == OFF_CNT_L);

  // A counter load restarts the tick phase so the loaded value lasts a full period
  assign prescClr   = !en || cntLoWr;
  assign countStep  = tick && en;
  assign matchEvent = countStep && (cnt == cmp);

  io_prescaler #(
    .PS_BITS (PRESCALE_BITS)
  ) uPrescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (prescClr),
    .ps    (ps),
    .tick  (tick)
  );

  // CTRL: bus write takes priority over the one-shot self-stop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en <= 1'b0;
      ie <= 1'b0;
      ar <= 1'b0;
      ps <= '0;
    end else if (ctrlWr) begin
      en <= bus.din[CTRL_EN];
      ie <= bus.din[CTRL_IE];
      ar <= bus.din[CTRL_AR];
      ps <= bus.din[CTRL_PS +: PRESCALE_BITS];
    end else if (matchEvent && !ar) begin
      en <= 1'b0;
    end
  end

  // Match flag: a new match beats any clear arriving in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mf <= 1'b0;
    end else if (matchEvent) begin
      mf <= 1'b1;
    end else if (bus.irq_clr || (statusWr && bus.din[STATUS_MF])) begin
      mf <= 1'b0;
    end
  end

  // Compare register, written byte by byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp <= CMP_RESET;
    end else begin
      if (cmpLoWr) cmp[7:0]  <= bus.din;
      if (cmpHiWr) cmp[15:8] <= bus.din;
    end
  end

  // High-byte staging for atomic counter loads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmpHi <= 8'd0;
    end else if (cntHiWr) begin
      tmpHi <= bus.din;
    end
  end

  // Counter: bus load wins over a tick; match reloads zero; 0xFFFF wraps silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 16'd0;
    end else if (cntLoWr) begin
      cnt <= {tmpHi, bus.din};
    end else if (matchEvent) begin
      cnt <= 16'd0;
    end else if (countStep) begin
      cnt <= cnt + 16'd1;
    end
  end

  // Reading the low byte freezes the high byte for the following read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cntHiShadow <= 8'd0;
    end else if (cntLoRd) begin
      cntHiShadow <= cnt[15:8];
    end
  end

`ifdef IO_TIMER_PWM_EN
  logic [15:0] duty;
  logic        pwmReg;

  // Duty register, written byte by byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty <= 16'd0;
    end else begin
      if (wrStrobe && (offset == OFF_DUTY_L)) duty[7:0]  <= bus.din;
      if (wrStrobe && (offset == OFF_DUTY_H)) duty[15:8] <= bus.din;
    end
  end

  // PWM high while running and the count is below the duty threshold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwmReg <= 1'b0;
    end else begin
      pwmReg <= en && (cnt < duty);
    end
  end

  assign pwm_out  = pwmReg;
  assign dutyRead = duty;
`else
  assign dutyRead = 16'd0;
`endif

  // Assemble the CTRL readback byte; unused bits read zero
  always_comb begin
    ctrlRead                           = 8'd0;
    ctrlRead[CTRL_EN]                  = en;
    ctrlRead[CTRL_IE]                  = ie;
    ctrlRead[CTRL_AR]                  = ar;
    ctrlRead[CTRL_PS +: PRESCALE_BITS] = ps;
  end

  // Read data selection by register offset
  always_comb begin
    readMux = 8'd0;
    case (offset)
      OFF_CTRL:   readMux = ctrlRead;
      OFF_STATUS: readMux = {7'd0, mf};
      OFF_CMP_L:  readMux = cmp[7:0];
      OFF_CMP_H:  readMux = cmp[15:8];
      OFF_CNT_L:  readMux = cnt[7:0];
      OFF_CNT_H:  readMux = cntHiShadow;
      OFF_DUTY_L: readMux = dutyRead[7:0];
      OFF_DUTY_H: readMux = dutyRead[15:8];
      default:    readMux = 8'd0;
    endcase
  end

  // Registered read port; idles at zero so the CPU-side OR/mux stays clean
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      doutReg <= 8'd0;
    end else if (rdStrobe) begin
      doutReg <= readMux;
    end else begin
      doutReg <= 8'd0;
    end
  end

  assign bus.dout = doutReg;
  assign bus.irq  = mf && ie;

endmodule
